id_stage: RTL and testbench



---
 rtl/id_stage.sv | 188 ++++++++++++++++++
 tb/tb_id_stage.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_stage.sv
// Decode stage: IF/ID latch, register file, immediate extension, early branch/jump
// resolution, hazard stall and the ID/EX register. ID_BYPASS_EN adds writeback-to-read bypass.
module id_stage #(
   parameter logic [31:0] NOP_INS  = 32'h00000000,
   parameter int          RF_DEPTH = 32
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic [31:0] IF_nextPC,
   input  logic [31:0] IF_Ins,
   input  logic        EX_RegWrite,
   input  logic        EX_MemRead,
   input  logic [4:0]  EX_Dst,
   input  logic        WB_WE,
   input  logic [4:0]  WB_Addr,
   input  logic [31:0] WB_Data,
   output logic        Stall,
   output logic        Redirect,
   output logic [31:0] TargetPC,
   output logic        ID_Valid,
   output logic [5:0]  ID_Opcode,
   output logic [5:0]  ID_Funct,
   output logic [4:0]  ID_Rs,
   output logic [4:0]  ID_Rt,
   output logic [4:0]  ID_Rd,
   output logic [31:0] ID_RsData,
   output logic [31:0] ID_RtData,
   output logic [31:0] ID_Imm,
   output logic [31:0] ID_nextPC
);

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_XORI  = 6'h0E;
   localparam logic [5:0] OP_LUI   = 6'h0F;
   localparam logic [5:0] OP_SW    = 6'h2B;

   logic [31:0] ifid_ins_reg;
   logic [31:0] ifid_pc_reg;
   logic [31:0] rf_reg [0:RF_DEPTH-1];
   logic [RF_DEPTH-1:0] rf_wr_en;

   logic [5:0]  op;
   logic [4:0]  rs;
   logic [4:0]  rt;
   logic [4:0]  rd_dec;
   logic [31:0] imm_ext;
   logic [31:0] rs_data;
   logic [31:0] rt_data;
   logic        rs_used;
   logic        rt_used;
   logic        dep;
   logic        is_branch;
   logic        is_jump;
   logic        taken;
   logic [31:0] br_target;
   logic [31:0] j_target;

   logic        id_valid_reg;
   logic [5:0]  id_opcode_reg;
   logic [5:0]  id_funct_reg;
   logic [4:0]  id_rs_reg;
   logic [4:0]  id_rt_reg;
   logic [4:0]  id_rd_reg;
   logic [31:0] id_rsdata_reg;
   logic [31:0] id_rtdata_reg;
   logic [31:0] id_imm_reg;
   logic [31:0] id_nextpc_reg;

   // Per-register write strobes; register 0 is never written.
   generate
      for (genvar gi = 0; gi < RF_DEPTH; gi++) begin : g_rf_we
         assign rf_wr_en[gi] = (gi != 0) && WB_WE && (WB_Addr == 5'(gi));
      end
   endgenerate

   always_ff @(posedge CLK) begin
      if (RST) begin
         for (int i = 0; i < RF_DEPTH; i++) rf_reg[i] <= '0;
      end else begin
         for (int i = 0; i < RF_DEPTH; i++)
            if (rf_wr_en[i]) rf_reg[i] <= WB_Data;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         ifid_ins_reg <= NOP_INS;
         ifid_pc_reg  <= '0;
      end else if (Redirect) begin
         ifid_ins_reg <= NOP_INS;
         ifid_pc_reg  <= '0;
      end else if (!Stall) begin
         ifid_ins_reg <= IF_Ins;
         ifid_pc_reg  <= IF_nextPC;
      end
   end

   assign op     = ifid_ins_reg[31:26];
   assign rs     = ifid_ins_reg[25:21];
   assign rt     = ifid_ins_reg[20:16];
   assign rd_dec = (op == OP_JAL) ? 5'd31 : ifid_ins_reg[15:11];

   always_comb begin
      case (op)
         OP_ANDI, OP_ORI, OP_XORI: imm_ext = {16'h0000, ifid_ins_reg[15:0]};
         OP_LUI:                   imm_ext = {ifid_ins_reg[15:0], 16'h0000};
         default:                  imm_ext = {{16{ifid_ins_reg[15]}}, ifid_ins_reg[15:0]};
      endcase
   end

   always_comb begin
      rs_data = (rs == 5'd0) ? 32'h0 : rf_reg[rs];
      rt_data = (rt == 5'd0) ? 32'h0 : rf_reg[rt];
`ifdef ID_BYPASS_EN
      if (WB_WE && (WB_Addr != 5'd0) && (WB_Addr == rs)) rs_data = WB_Data;
      if (WB_WE && (WB_Addr != 5'd0) && (WB_Addr == rt)) rt_data = WB_Data;
`endif
   end

   // Jumps carry no register sources; Rt is a source only for these opcodes.
   assign rs_used   = (op != OP_J) && (op != OP_JAL);
   assign rt_used   = (op == OP_RTYPE) || (op == OP_SW) || (op == OP_BEQ) || (op == OP_BNE);
   assign dep       = (EX_Dst != 5'd0) &&
                      ((rs_used && (EX_Dst == rs)) || (rt_used && (EX_Dst == rt)));
   assign is_branch = (op == OP_BEQ) || (op == OP_BNE);
   assign is_jump   = (op == OP_J) || (op == OP_JAL);

   assign Stall = (EX_MemRead && dep) || (is_branch && EX_RegWrite && dep);

   always_comb begin
      taken = 1'b0;
      case (op)
         OP_BEQ:       taken = (rs_data == rt_data);
         OP_BNE:       taken = (rs_data != rt_data);
         OP_J, OP_JAL: taken = 1'b1;
         default:      taken = 1'b0;
      endcase
   end

   assign br_target = ifid_pc_reg + {{14{ifid_ins_reg[15]}}, ifid_ins_reg[15:0], 2'b00};
   assign j_target  = {ifid_pc_reg[31:28], ifid_ins_reg[25:0], 2'b00};
   assign Redirect  = taken && !Stall;
   assign TargetPC  = !Redirect ? 32'h0 : (is_jump ? j_target : br_target);

   always_ff @(posedge CLK) begin
      if (RST || Stall) begin
         id_valid_reg  <= 1'b0;
         id_opcode_reg <= '0;
         id_funct_reg  <= '0;
         id_rs_reg     <= '0;
         id_rt_reg     <= '0;
         id_rd_reg     <= '0;
         id_rsdata_reg <= '0;
         id_rtdata_reg <= '0;
         id_imm_reg    <= '0;
         id_nextpc_reg <= '0;
      end else begin
         id_valid_reg  <= (ifid_ins_reg != NOP_INS);
         id_opcode_reg <= op;
         id_funct_reg  <= ifid_ins_reg[5:0];
         id_rs_reg     <= rs;
         id_rt_reg     <= rt;
         id_rd_reg     <= rd_dec;
         id_rsdata_reg <= rs_data;
         id_rtdata_reg <= rt_data;
         id_imm_reg    <= imm_ext;
         id_nextpc_reg <= ifid_pc_reg;
      end
   end

   assign ID_Valid  = id_valid_reg;
   assign ID_Opcode = id_opcode_reg;
   assign ID_Funct  = id_funct_reg;
   assign ID_Rs     = id_rs_reg;
   assign ID_Rt     = id_rt_reg;
   assign ID_Rd     = id_rd_reg;
   assign ID_RsData = id_rsdata_reg;
   assign ID_RtData = id_rtdata_reg;
   assign ID_Imm    = id_imm_reg;
   assign ID_nextPC = id_nextpc_reg;

endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: expected ID/EX records are queued as instructions are driven
// and compared when they reach the ID_* outputs; combinational outputs are checked in place.
module tb_id_stage;

   typedef struct packed {
      logic        valid;
      logic [5:0]  opcode;
      logic [5:0]  funct;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic [4:0]  rd;
      logic [31:0] rsdata;
      logic [31:0] rtdata;
      logic [31:0] imm;
      logic [31:0] npc;
   } idex_t;

   logic        CLK;
   logic        RST;
   logic [31:0] IF_nextPC;
   logic [31:0] IF_Ins;
   logic        EX_RegWrite;
   logic        EX_MemRead;
   logic [4:0]  EX_Dst;
   logic        WB_WE;
   logic [4:0]  WB_Addr;
   logic [31:0] WB_Data;
   logic        Stall;
   logic        Redirect;
   logic [31:0] TargetPC;
   logic        ID_Valid;
   logic [5:0]  ID_Opcode;
   logic [5:0]  ID_Funct;
   logic [4:0]  ID_Rs;
   logic [4:0]  ID_Rt;
   logic [4:0]  ID_Rd;
   logic [31:0] ID_RsData;
   logic [31:0] ID_RtData;
   logic [31:0] ID_Imm;
   logic [31:0] ID_nextPC;

   idex_t       obs;
   idex_t       sb_q [$];
   string       tag_q [$];
   logic [31:0] model_rf [32];
   int          cmp_cnt = 0;
   int          fail_cnt = 0;

   localparam logic [31:0] NOP   = 32'h00000000;
   localparam logic [31:0] ADDI  = 32'h2023FFFC;  // addi r3,r1,-4
   localparam logic [31:0] OR65  = 32'h00A23025;  // or   r6,r5,r2
   localparam logic [31:0] ADD   = 32'h00412020;  // add  r4,r2,r1
   localparam logic [31:0] ORI   = 32'h3407ABCD;  // ori  r7,r0,0xABCD
   localparam logic [31:0] BEQ   = 32'h10220003;  // beq  r1,r2,+3
   localparam logic [31:0] BNE   = 32'h14220003;  // bne  r1,r2,+3
   localparam logic [31:0] BEQM1 = 32'h1000FFFF;  // beq  r0,r0,-1
   localparam logic [31:0] JMP   = 32'h08040000;  // j    0x0040000
   localparam logic [31:0] JAL   = 32'h0C000010;  // jal  0x10
   localparam logic [31:0] OR00  = 32'h00004025;  // or   r8,r0,r0

   id_stage dut (
      .CLK(CLK), .RST(RST), .IF_nextPC(IF_nextPC), .IF_Ins(IF_Ins),
      .EX_RegWrite(EX_RegWrite), .EX_MemRead(EX_MemRead), .EX_Dst(EX_Dst),
      .WB_WE(WB_WE), .WB_Addr(WB_Addr), .WB_Data(WB_Data),
      .Stall(Stall), .Redirect(Redirect), .TargetPC(TargetPC),
      .ID_Valid(ID_Valid), .ID_Opcode(ID_Opcode), .ID_Funct(ID_Funct),
      .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_Rd(ID_Rd),
      .ID_RsData(ID_RsData), .ID_RtData(ID_RtData),
      .ID_Imm(ID_Imm), .ID_nextPC(ID_nextPC)
   );

   assign obs = {ID_Valid, ID_Opcode, ID_Funct, ID_Rs, ID_Rt, ID_Rd,
                 ID_RsData, ID_RtData, ID_Imm, ID_nextPC};

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   function automatic idex_t model(input logic [31:0] ins, input logic [31:0] npc,
                                   input logic [31:0] rsv, input logic [31:0] rtv);
      idex_t e;
      logic [5:0] op;
      op       = ins[31:26];
      e.valid  = (ins != NOP);
      e.opcode = op;
      e.funct  = ins[5:0];
      e.rs     = ins[25:21];
      e.rt     = ins[20:16];
      e.rd     = (op == 6'h03) ? 5'd31 : ins[15:11];
      e.rsdata = rsv;
      e.rtdata = rtv;
      if (op == 6'h0C || op == 6'h0D || op == 6'h0E) e.imm = {16'h0, ins[15:0]};
      else if (op == 6'h0F)                          e.imm = {ins[15:0], 16'h0};
      else                                           e.imm = {{16{ins[15]}}, ins[15:0]};
      e.npc = npc;
      return e;
   endfunction

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic push_exp(input string tag, input logic [31:0] ins, input logic [31:0] npc);
      sb_q.push_back(model(ins, npc, model_rf[ins[25:21]], model_rf[ins[20:16]]));
      tag_q.push_back(tag);
   endtask

   task automatic push_raw(input string tag, input idex_t e);
      sb_q.push_back(e);
      tag_q.push_back(tag);
   endtask

   task automatic pop_cmp();
      idex_t e;
      string t;
      cmp_cnt++;
      if (sb_q.size() == 0) begin
         fail_cnt++;
         $error("FAIL sb_empty: observed %h required a queued record", obs);
      end else begin
         e = sb_q.pop_front();
         t = tag_q.pop_front();
         assert (obs === e) else begin
            fail_cnt++;
            $error("FAIL %s: observed %h required %h", t, obs, e);
         end
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
      cmp_cnt++;
      assert (o === e) else begin
         fail_cnt++;
         $error("FAIL %s: observed %h required %h", tag, o, e);
      end
   endtask

   task automatic feed(input logic [31:0] ins, input logic [31:0] npc);
      IF_Ins    = ins;
      IF_nextPC = npc;
      tick();
   endtask

   task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
      WB_WE   = 1'b1;
      WB_Addr = a;
      WB_Data = d;
      tick();
      WB_WE = 1'b0;
      if (a != 5'd0) model_rf[a] = d;
   endtask

   initial begin
      for (int i = 0; i < 32; i++) model_rf[i] = 32'h0;
      RST = 1'b1; IF_Ins = NOP; IF_nextPC = 32'h0;
      EX_RegWrite = 1'b0; EX_MemRead = 1'b0; EX_Dst = 5'd0;
      WB_WE = 1'b1; WB_Addr = 5'd5; WB_Data = 32'hDEADBEEF;

      // Reset with a pending writeback to r5
      push_raw("reset_idex", '0);
      tick();
      tick();
      pop_cmp();
      chk("reset_stall", {31'b0, Stall}, 32'd0);
      chk("reset_redirect", {31'b0, Redirect}, 32'd0);
      chk("reset_target", TargetPC, 32'h0);
      RST = 1'b0; WB_WE = 1'b0;

      // Basic decode
      write_reg(5'd1, 32'h10);
      write_reg(5'd2, 32'h20);
      feed(ADDI, 32'h100);
      IF_Ins = NOP;
      push_exp("addi", ADDI, 32'h100);
      tick();
      pop_cmp();
      chk("addi_rsdata", ID_RsData, 32'h10);
      chk("addi_imm", ID_Imm, 32'hFFFFFFFC);
      chk("addi_rt", {27'b0, ID_Rt}, 32'd3);

      // r5 must have stayed cleared through reset
      feed(OR65, 32'h104);
      IF_Ins = NOP;
      push_exp("or_r5", OR65, 32'h104);
      tick();
      pop_cmp();
      chk("r5_after_reset", ID_RsData, 32'h0);

      // Load-use stall for one cycle
      feed(ADD, 32'h200);
      IF_Ins = ORI; IF_nextPC = 32'h204;
      EX_MemRead = 1'b1; EX_Dst = 5'd2;
      #1;
      chk("lu_stall", {31'b0, Stall}, 32'd1);
      chk("lu_redirect", {31'b0, Redirect}, 32'd0);
      push_raw("lu_bubble", '0);
      tick();
      pop_cmp();
      EX_MemRead = 1'b0; EX_Dst = 5'd0;
      #1;
      chk("lu_release", {31'b0, Stall}, 32'd0);
      push_exp("lu_add", ADD, 32'h200);
      tick();
      IF_Ins = NOP;
      pop_cmp();
      push_exp("ori_zext", ORI, 32'h204);
      tick();
      pop_cmp();

      // No stall on EX_Dst=0, nor when EX_Dst matches only a destination field
      feed(ADD, 32'h300);
      IF_Ins = NOP;
      EX_MemRead = 1'b1; EX_Dst = 5'd0;
      #1;
      chk("lu_dst0", {31'b0, Stall}, 32'd0);
      push_exp("add_dst0", ADD, 32'h300);
      tick();
      pop_cmp();
      feed(ADDI, 32'h304);
      EX_Dst = 5'd3;
      #1;
      chk("lu_rt_is_dest", {31'b0, Stall}, 32'd0);
      push_exp("addi_nodep", ADDI, 32'h304);
      tick();
      pop_cmp();
      EX_MemRead = 1'b0; EX_Dst = 5'd0;

      // Branch operand hazard, then a taken BEQ with flush
      write_reg(5'd1, 32'd7);
      write_reg(5'd2, 32'd7);
      feed(BEQ, 32'h104);
      IF_Ins = ADDI; IF_nextPC = 32'h108;
      EX_RegWrite = 1'b1; EX_Dst = 5'd1;
      #1;
      chk("br_hz_stall", {31'b0, Stall}, 32'd1);
      chk("br_hz_redirect", {31'b0, Redirect}, 32'd0);
      chk("br_hz_target", TargetPC, 32'h0);
      push_raw("br_hz_bubble", '0);
      tick();
      pop_cmp();
      EX_RegWrite = 1'b0; EX_Dst = 5'd0;
      #1;
      chk("beq_redirect", {31'b0, Redirect}, 32'd1);
      chk("beq_target", TargetPC, 32'h110);
      push_exp("beq", BEQ, 32'h104);
      tick();
      IF_Ins = NOP;
      pop_cmp();
      chk("flush_redirect", {31'b0, Redirect}, 32'd0);
      tick();
      chk("flush_valid", {31'b0, ID_Valid}, 32'd0);

      // BNE with equal operands falls through
      feed(BNE, 32'h104);
      IF_Ins = NOP;
      #1;
      chk("bne_redirect", {31'b0, Redirect}, 32'd0);
      chk("bne_target", TargetPC, 32'h0);
      push_exp("bne", BNE, 32'h104);
      tick();
      pop_cmp();

      // Backward branch wraps modulo 2^32
      feed(BEQM1, 32'h0);
      IF_Ins = NOP;
      #1;
      chk("beq_back_target", TargetPC, 32'hFFFFFFFC);
      push_exp("beq_back", BEQM1, 32'h0);
      tick();
      pop_cmp();

      // Jumps; r0 write is ignored
      write_reg(5'd0, 32'hFFFFFFFF);
      feed(JMP, 32'h40000004);
      IF_Ins = NOP;
      #1;
      chk("j_redirect", {31'b0, Redirect}, 32'd1);
      chk("j_target", TargetPC, 32'h40100000);
      push_exp("j", JMP, 32'h40000004);
      tick();
      pop_cmp();
      feed(JAL, 32'h8);
      IF_Ins = NOP;
      #1;
      chk("jal_target", TargetPC, 32'h40);
      push_exp("jal", JAL, 32'h8);
      tick();
      pop_cmp();
      chk("jal_rd", {27'b0, ID_Rd}, 32'd31);
      feed(OR00, 32'h10);
      IF_Ins = NOP;
      push_exp("or_r0", OR00, 32'h10);
      tick();
      pop_cmp();
      chk("r0_zero", ID_RsData, 32'h0);

      // Writeback in the same cycle ID reads r1
      feed(ADDI, 32'h400);
      IF_Ins = NOP;
      WB_WE = 1'b1; WB_Addr = 5'd1; WB_Data = 32'h55;
`ifdef ID_BYPASS_EN
      push_raw("bypass", model(ADDI, 32'h400, 32'h55, model_rf[3]));
`else
      push_raw("no_bypass", model(ADDI, 32'h400, model_rf[1], model_rf[3]));
`endif
      tick();
      WB_WE = 1'b0;
      model_rf[1] = 32'h55;
      pop_cmp();
      feed(ADDI, 32'h404);
      IF_Ins = NOP;
      push_exp("after_wb", ADDI, 32'h404);
      tick();
      pop_cmp();
      chk("r1_written", ID_RsData, 32'h55);

      chk("sb_drained", sb_q.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, fail_cnt);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout required completion");
      $fatal(1, "timeout");
   end

endmodule
